// File: rtl/turn_signal_ctrl.sv
// turn_signal_ctrl: turn/hazard/reverse lamp controller with programmable blink half-period.
module turn_signal_ctrl #(
  parameter int HALF_PERIOD = 25_000_000,
  parameter int MIN_FLASHES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_now,
  input  logic [3:0] state,
  input  logic [3:0] answer,
  input  logic       hazard_req,
  output logic       left_led,
  output logic       right_led,
  output logic       reverse_led,
  output logic       blink_phase
);
  localparam int CW = HALF_PERIOD > 1 ? $clog2(HALF_PERIOD) : 1;
  localparam int FW = MIN_FLASHES > 0 ? $clog2(MIN_FLASHES + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(HALF_PERIOD - 1);
  localparam logic [FW-1:0] FMAX = FW'(MIN_FLASHES);
  typedef enum logic [2:0] {S_OFF, S_IDLE, S_LEFT, S_RIGHT, S_HAZARD} st_t;
  st_t st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] flash_cnt_q, flash_cnt_d;
  logic phase_q, phase_d;
  logic left_q, left_d, right_q, right_d, rev_q, rev_d, blink_q, blink_d;
  logic drive_en, done, wrap, flashing, enter, turn;
  assign drive_en = (state == 4'b0010) || (state == 4'b0100);
  assign done     = (flash_cnt_q >= FMAX) && !phase_q;
  assign wrap     = cnt_q == CMAX;
  assign turn     = (st_q == S_LEFT) || (st_q == S_RIGHT);
  always_comb begin
    st_d = st_q;
    if (power_now) st_d = S_OFF;
    else if (hazard_req) st_d = S_HAZARD;
    else case (st_q)
      S_OFF:    st_d = S_IDLE;
      S_HAZARD: st_d = S_IDLE;
      S_IDLE:   st_d = !drive_en ? S_IDLE : (answer[3:2] == 2'b10) ? S_LEFT :
                       (answer[3:2] == 2'b01) ? S_RIGHT : S_IDLE;
      S_LEFT:   st_d = !drive_en ? S_IDLE : (answer[2] && !answer[3]) ? S_RIGHT :
                       (!answer[3] && done) ? S_IDLE : S_LEFT;
      S_RIGHT:  st_d = !drive_en ? S_IDLE : (answer[3] && !answer[2]) ? S_LEFT :
                       (!answer[2] && done) ? S_IDLE : S_RIGHT;
      default:  st_d = S_OFF;
    endcase
  end
  assign flashing = (st_d == S_LEFT) || (st_d == S_RIGHT) || (st_d == S_HAZARD);
  assign enter    = flashing && (st_d != st_q);
  always_comb begin
    cnt_d       = enter || !flashing || wrap ? '0 : cnt_q + CW'(1);
    phase_d     = enter ? 1'b1 : !flashing ? 1'b0 : phase_q ^ wrap;
    flash_cnt_d = enter || !flashing ? '0 :
                  (wrap && phase_q && turn && flash_cnt_q < FMAX) ? flash_cnt_q + FW'(1) : flash_cnt_q;
    left_d      = phase_q && (st_q == S_LEFT || st_q == S_HAZARD) && !power_now;
    right_d     = phase_q && (st_q == S_RIGHT || st_q == S_HAZARD) && !power_now;
    rev_d       = !power_now && drive_en && answer[1];
    blink_d     = phase_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= S_OFF;
      cnt_q       <= '0;
      phase_q     <= 1'b0;
      flash_cnt_q <= '0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      rev_q       <= 1'b0;
      blink_q     <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      phase_q     <= phase_d;
      flash_cnt_q <= flash_cnt_d;
      left_q      <= left_d;
      right_q     <= right_d;
      rev_q       <= rev_d;
      blink_q     <= blink_d;
    end
  end
  assign left_led    = left_q;
  assign right_led   = right_q;
  assign reverse_led = rev_q;
  assign blink_phase = blink_q;
endmodule
